adder_tree_pipe: RTL and testbench
==================================

# adder_tree_pipe

Parametrised, fully pipelined adder tree. It sums `NUM_IN` operands of `WIDTH` bits each. One register stage per tree level gives one vector per cycle throughput. It supports signed or unsigned operands, valid/ready flow control with backpressure, and optional multi-beat accumulation of successive vectors into one result. It sits wherever the datapath reduces a bank of lane results to a single sum and replaces the fixed-size, fixed-level trees.

## Interface
- `NUM_IN`, default 8: operand count; a power of two, 2..64. `LEVELS = log2(NUM_IN)`.
- `WIDTH`, default 28: operand width in bits, 1..64.
- `SIGNED`, default 0: 1 = two's-complement operands, sign-extended; 0 = zero-extended.
- `ACC_BITS`, default 4: extra accumulator headroom bits. `OUT_W = WIDTH + LEVELS + ACC_BITS`.
- `clk`, input, 1: sole clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `in_data`/`in_last` valid.
- `in_ready`, output, 1: block accepts a beat this cycle.
- `in_data`, input, `NUM_IN*WIDTH`: operand i at bits `[i*WIDTH +: WIDTH]`.
- `in_last`, input, 1: final beat of an accumulation frame. Tie to 1 for plain one-vector sums.
- `out_valid`, output, 1: `out_sum` holds a completed frame sum.
- `out_ready`, input, 1: downstream accepts `out_sum`.
- `out_sum`, output, `OUT_W`: frame sum.

## Operation
- **Acceptance.** A beat is accepted on an edge where `in_valid && in_ready`.
- **Pipeline advance.** The pipeline advances when `adv = !out_valid || out_ready`. `in_ready = adv`, combinational.
- **Global stall.** When `adv` is 0, every stage register, valid bit, last bit and the accumulator hold their values.
- **Stage 0.** Registers `in_data`, `in_last` and the valid bit.
- **Stage k (1..LEVELS).** Registers pairwise sums of stage k-1. Each sum is one bit wider than its operands and is computed after sign- or zero-extension per `SIGNED`. Stage `LEVELS` holds the tree sum `T` (`WIDTH+LEVELS` bits, exact, no overflow possible).
- **Valid and last tracking.** Each stage carries its own valid and last bit. A stage whose valid bit is 0 contributes nothing to the accumulator.
- **Accumulate stage, on `adv` with tree valid.**
  - `T` is extended to `OUT_W` per `SIGNED`.
  - If last: `out_sum <= acc + T`, `acc <= 0`, `out_valid <= 1`.
  - If not last: `acc <= acc + T`, `out_valid <= 0`.
- **Accumulate stage, on `adv` with tree invalid.** `out_valid <= 0`; `acc` holds.
- **Accumulator overflow.** Arithmetic wraps modulo 2^`OUT_W`. There is no saturation and no overflow flag. Frames of at most 2^`ACC_BITS` beats are exact.
- **`out_sum` stability.** `out_sum` is stable while `out_valid && !out_ready`.
- **Reset.** On `rst`: all valid bits 0, `out_valid` 0, `out_sum` 0, `acc` 0.
  - Stage data registers need no reset.
  - Reset mid-frame discards the partial accumulation and all beats in flight.
  - `in_ready` is 1 in the first cycle after reset.

## Timing
- **Latency.** For a beat accepted on edge E, the tree sum reaches the accumulate stage on edge E+`LEVELS`. `out_sum`/`out_valid` update on edge E+`LEVELS`+1, assuming no stalls.
  - Default config (`LEVELS`=3): result visible 4 edges after acceptance.
- **Throughput.** One beat per cycle when `out_ready` is held at 1.
- **Backpressure.** Each cycle with `out_valid && !out_ready` adds exactly one cycle of delay to all in-flight beats. No beat is dropped or duplicated.
- **Combinational paths.** `in_ready` depends combinationally on `out_ready` and `out_valid` only. There is no path from `in_data` to any output.
- **Handshake rules.**
  - `in_valid` may assert without waiting for `in_ready`.
  - `in_data` may change freely while not accepted.
  - Downstream must not require `out_valid` to drop between consecutive results; back-to-back frames give `out_valid` high on consecutive cycles.

## Test plan
All scenarios use defaults (`NUM_IN`=8, `WIDTH`=28, `ACC_BITS`=4, `OUT_W`=35) unless stated otherwise.

1. **Basic sum.** Operands 1..8, `in_last`=1, `out_ready`=1 → `out_sum`=36, `out_valid` high for exactly one cycle, 4 edges after acceptance.
2. **Unsigned max.** All operands 0xFFFFFFF, `in_last`=1 → `out_sum`=0x7FFFFFF8.
3. **Signed.** `SIGNED`=1, all operands 0x8000000 (−2^27), `in_last`=1 → `out_sum`=0x7C0000000 (−2^30 in 35 bits).
4. **Accumulation.** Three back-to-back beats of all-ones operands (value 1), `in_last` only on the third → single result `out_sum`=24. `out_valid` stays 0 for the first two beats.
5. **Backpressure.** Stream 6 single-beat vectors with sums 8, 16, …, 48. Hold `out_ready`=0 for 3 cycles after the first result → `in_ready` is 0 during the hold, all 6 sums emerge in order with none lost or repeated, and `out_sum` is held at 8 during the stall.
6. **Reset mid-frame.** Two non-last beats of value 5, then `rst` for 1 cycle, then one beat of all-2 with `in_last`=1 → `out_sum`=16. No output for the discarded beats.

Source files
------------

// File: rtl/adder_tree_pipe.sv
// Pipelined adder tree: one register stage per tree level, then an accumulate stage
// that folds successive tree sums into one frame result under valid/ready flow control.
module adder_tree_pipe #(
    parameter int NUM_IN   = 8,
    parameter int WIDTH    = 28,
    parameter int SIGNED   = 0,
    parameter int ACC_BITS = 4,
    localparam int LEVELS  = $clog2(NUM_IN),
    localparam int OUT_W   = WIDTH + LEVELS + ACC_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_sum
);

    localparam bit SGN = (SIGNED != 0);
    localparam int TW  = WIDTH + LEVELS;

    // Handshake: a beat moves on an edge where in_valid && in_ready. The whole pipe
    // advances together whenever the output register is empty or being drained, so
    // in_ready is a pure function of out_valid and out_ready.
    logic adv;
    logic accept;

    logic [LEVELS:0] vld_q;
    logic [LEVELS:0] vld_d;
    logic [LEVELS:0] lst_q;
    logic [LEVELS:0] lst_d;

    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] acc_d;
    logic [OUT_W-1:0] sum_q;
    logic [OUT_W-1:0] sum_d;
    logic             out_valid_q;
    logic             out_valid_d;

    logic [TW-1:0]    tree_sum;
    logic [OUT_W-1:0] tree_ext;

    assign adv      = !out_valid_q || out_ready;
    assign accept   = in_valid && adv;
    assign in_ready = adv;

    assign vld_d = {vld_q[LEVELS-1:0], accept};
    assign lst_d = {lst_q[LEVELS-1:0], in_last};

    // Level k holds NUM_IN>>k partial sums of WIDTH+k bits each; level 0 is the input register.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        localparam int N = NUM_IN >> k;
        localparam int W = WIDTH + k;

        logic [N*W-1:0] data_q;
        logic [N*W-1:0] data_d;

        if (k == 0) begin : g_in
            assign data_d = in_data;
        end else begin : g_sum
            localparam int PW = W - 1;
            for (genvar i = 0; i < N; i++) begin : g_pair
                logic [PW-1:0] a;
                logic [PW-1:0] b;
                assign a = g_lvl[k-1].data_q[(2*i)*PW +: PW];
                assign b = g_lvl[k-1].data_q[(2*i+1)*PW +: PW];
                // One extra bit per level keeps every pairwise sum exact.
                assign data_d[i*W +: W] = {SGN & a[PW-1], a} + {SGN & b[PW-1], b};
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                data_q <= data_d;
            end
        end
    end

    assign tree_sum = g_lvl[LEVELS].data_q;

    if (ACC_BITS > 0) begin : g_ext
        assign tree_ext = {{ACC_BITS{SGN & tree_sum[TW-1]}}, tree_sum};
    end else begin : g_noext
        assign tree_ext = tree_sum;
    end

    // Last bits travel with the data and need no reset; only valid bits do.
    always_ff @(posedge clk) begin
        if (adv) begin
            lst_q <= lst_d;
        end
    end

    always_comb begin
        acc_d       = acc_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            out_valid_d = 1'b0;
            if (vld_q[LEVELS]) begin
                if (lst_q[LEVELS]) begin
                    sum_d       = acc_q + tree_ext;
                    acc_d       = '0;
                    out_valid_d = 1'b1;
                end else begin
                    acc_d = acc_q + tree_ext;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (adv) begin
                vld_q <= vld_d;
            end
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: an unsigned and a signed instance share one stimulus stream;
// each has its own expected queue filled by an arithmetic frame model.
module tb_adder_tree_pipe;

    localparam int NUM_IN = 8;
    localparam int WIDTH  = 28;
    localparam int OUT_W  = 35;
    localparam int DW     = NUM_IN * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid  = 1'b0;
    logic          in_last   = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in_data   = '0;

    logic             in_ready_u, in_ready_s;
    logic             out_valid_u, out_valid_s;
    logic [OUT_W-1:0] out_sum_u, out_sum_s;

    adder_tree_pipe #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .SIGNED(0), .ACC_BITS(4)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid_u), .out_ready(out_ready), .out_sum(out_sum_u)
    );

    adder_tree_pipe #(.NUM_IN(NUM_IN), .WIDTH(WIDTH), .SIGNED(1), .ACC_BITS(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s)
    );

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] exp_u_q[$];
    logic [OUT_W-1:0] exp_s_q[$];
    longint acc_u = 0;
    longint acc_s = 0;
    bit bp_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic longint lane_val(input logic [WIDTH-1:0] x, input bit sgn);
        longint v;
        v = longint'(x);
        if (sgn && x[WIDTH-1]) v = v - (longint'(1) << WIDTH);
        return v;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [WIDTH-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < NUM_IN; i++) r[i*WIDTH +: WIDTH] = v;
        return r;
    endfunction

    // Reference model: frame sum of all lanes over all beats, modulo 2^OUT_W.
    task automatic model_accept(input logic [DW-1:0] d, input logic last);
        logic [63:0] t;
        for (int i = 0; i < NUM_IN; i++) begin
            acc_u += lane_val(d[i*WIDTH +: WIDTH], 1'b0);
            acc_s += lane_val(d[i*WIDTH +: WIDTH], 1'b1);
        end
        if (last) begin
            t = acc_u;
            exp_u_q.push_back(t[OUT_W-1:0]);
            t = acc_s;
            exp_s_q.push_back(t[OUT_W-1:0]);
            acc_u = 0;
            acc_s = 0;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int b;
        b = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!(in_ready_u && in_ready_s)) begin
            b++;
            if (b > 200) begin
                fail_now("send_beat");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        model_accept(d, last);
        #1;
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int b;
        b = 0;
        @(negedge clk);
        while (!out_valid_u) begin
            b++;
            if (b > 50) begin
                fail_now(name);
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain(input string name);
        int b;
        b = 0;
        while ((exp_u_q.size() != 0 || exp_s_q.size() != 0) && b < 400) begin
            @(posedge clk);
            b++;
        end
        #1;
        check({name, "_u_left"}, exp_u_q.size(), 0);
        check({name, "_s_left"}, exp_s_q.size(), 0);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        acc_u = 0;
        acc_s = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops the expected queue on every output handshake and checks hold during stalls.
    logic [OUT_W-1:0] held_u, held_s, e_u, e_s;
    bit stall_u = 1'b0;
    bit stall_s = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_u = 1'b0;
                stall_s = 1'b0;
            end else begin
                if (stall_u) begin
                    check("hold_valid_u", out_valid_u, 1);
                    check("hold_sum_u", out_sum_u, held_u);
                end
                if (stall_s) begin
                    check("hold_valid_s", out_valid_s, 1);
                    check("hold_sum_s", out_sum_s, held_s);
                end
                if (out_valid_u && out_ready) begin
                    if (exp_u_q.size() == 0) begin
                        fail_now("unexpected_out_u");
                    end else begin
                        e_u = exp_u_q.pop_front();
                        check("sum_u", out_sum_u, e_u);
                    end
                end
                if (out_valid_s && out_ready) begin
                    if (exp_s_q.size() == 0) begin
                        fail_now("unexpected_out_s");
                    end else begin
                        e_s = exp_s_q.pop_front();
                        check("sum_s", out_sum_s, e_s);
                    end
                end
                stall_u = out_valid_u && !out_ready;
                stall_s = out_valid_s && !out_ready;
                held_u  = out_sum_u;
                held_s  = out_sum_s;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid_u, 0);
        check("rst_out_sum", out_sum_u, 0);
        check("rst_in_ready", in_ready_u, 1);
        check("rst_out_valid_s", out_valid_s, 0);
        @(posedge clk);
        #1;

        // Basic sum 1..8 and its latency/one-cycle valid.
        begin
            logic [DW-1:0] d;
            for (int i = 0; i < NUM_IN; i++) d[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
            send_beat(d, 1'b1);
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                check("lat_valid", out_valid_u, (c == 5) ? 1 : 0);
                if (c == 5) begin
                    check("basic_u", out_sum_u, 36);
                    check("basic_s", out_sum_s, 36);
                end
            end
            @(posedge clk);
            #1;
        end

        // Unsigned max; the signed instance sees eight -1 lanes.
        send_beat(fill(28'hFFFFFFF), 1'b1);
        wait_valid("max_wait");
        check("max_u", out_sum_u, 35'h07FFFFFF8);
        check("max_s", out_sum_s, 35'h7FFFFFFF8);
        @(posedge clk);
        #1;

        // Most negative operands.
        send_beat(fill(28'h8000000), 1'b1);
        wait_valid("neg_wait");
        check("neg_u", out_sum_u, 35'h040000000);
        check("neg_s", out_sum_s, 35'h7C0000000);
        @(posedge clk);
        #1;

        // Three-beat accumulation frame.
        send_beat(fill(28'd1), 1'b0);
        send_beat(fill(28'd1), 1'b0);
        send_beat(fill(28'd1), 1'b1);
        wait_valid("acc_wait");
        check("acc_u", out_sum_u, 24);
        check("acc_s", out_sum_s, 24);
        @(posedge clk);
        #1;
        drain("directed");

        // Backpressure: stall the first of six results for three cycles.
        fork
            begin
                for (int k = 1; k <= 6; k++) send_beat(fill(WIDTH'(k)), 1'b1);
            end
            begin
                int b;
                b = 0;
                do begin
                    @(posedge clk);
                    #1;
                    b++;
                end while (!out_valid_u && b < 50);
                if (!out_valid_u) fail_now("bp_wait");
                out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("bp_in_ready", in_ready_u, 0);
                    check("bp_held_sum", out_sum_u, 8);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("bp");

        // Reset in the middle of a frame discards the partial sum.
        send_beat(fill(28'd5), 1'b0);
        send_beat(fill(28'd5), 1'b0);
        idle(2);
        do_reset();
        @(negedge clk);
        check("mid_rst_valid", out_valid_u, 0);
        check("mid_rst_sum", out_sum_u, 0);
        check("mid_rst_ready", in_ready_u, 1);
        @(posedge clk);
        #1;
        send_beat(fill(28'd2), 1'b1);
        wait_valid("rst_frame_wait");
        check("rst_frame_u", out_sum_u, 16);
        check("rst_frame_s", out_sum_s, 16);
        @(posedge clk);
        #1;
        drain("reset");

        // Random frames under random backpressure, including long frames that wrap.
        bp_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = (f % 10 == 9) ? $urandom_range(17, 20) : $urandom_range(1, 4);
            for (int bt = 0; bt < len; bt++) begin
                logic [DW-1:0] d;
                int mode;
                mode = $urandom_range(0, 3);
                for (int i = 0; i < NUM_IN; i++) begin
                    case (mode)
                        0:       d[i*WIDTH +: WIDTH] = WIDTH'($urandom());
                        1:       d[i*WIDTH +: WIDTH] = 28'hFFFFFFF;
                        2:       d[i*WIDTH +: WIDTH] = 28'h8000000;
                        default: d[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 15));
                    endcase
                end
                send_beat(d, (bt == len - 1) ? 1'b1 : 1'b0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        bp_rand = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
